// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: registered N:1 channel mux with a manual select mode
// and an automatic round-robin scan mode that dwells DWELL cycles per channel.
//
// Parameters:
//   WIDTH     data width per channel
//   CHANNELS  number of input channels (2..16)
//   DWELL     cycles spent on each channel while scanning (1..255)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   din         flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel         manual channel select
//   en          enable; low = idle
//   mode        0 = manual select, 1 = round-robin scan
//   dout        registered selected data
//   dout_valid  dout was captured on the previous edge
//   cur_ch      channel dout was taken from
//   wrap        one-cycle pulse on the first channel-0 sample after a full scan
//   sel_err     manual select was out of range
//   dout_par    (only with MUX_NX1_PARITY_EN) XOR-reduce of dout
//
// Build option: define MUX_NX1_PARITY_EN to add the dout_par output.
module mux_nx1_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS*WIDTH-1:0]   din,
    input  logic [$clog2(CHANNELS)-1:0] sel,
    input  logic                        en,
    input  logic                        mode,
    output logic [WIDTH-1:0]            dout,
    output logic                        dout_valid,
    output logic [$clog2(CHANNELS)-1:0] cur_ch,
    output logic                        wrap,
    output logic                        sel_err
`ifdef MUX_NX1_PARITY_EN
    ,
    output logic                        dout_par
`endif
);

    localparam int SEL_W = $clog2(CHANNELS);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_LIM     = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Scan position holds the channel/dwell of the NEXT scan sample.
    // It is cleared whenever the block is not scanning, so entry into
    // scan always starts from channel 0, dwell 0.
    logic [SEL_W-1:0] scan_ch;
    logic [SEL_W-1:0] scan_ch_nx;
    logic [DW_W-1:0]  dwell;
    logic [DW_W-1:0]  dwell_nx;

    logic [WIDTH-1:0] dout_nx;
    logic [SEL_W-1:0] cur_ch_nx;
    logic             valid_nx;
    logic             wrap_nx;
    logic             err_nx;

    logic             sel_bad;
    logic [SEL_W-1:0] mux_idx;
    logic [WIDTH-1:0] data_sel;

    assign sel_bad = ({1'b0, sel} >= CH_LIM);

    always_comb begin
        state_nx = IDLE;
        if (en) begin
            state_nx = mode ? SCAN : MAN;
        end
    end

    // Out-of-range selects are steered to channel 0 so the mux
    // never indexes outside din; that data is discarded anyway.
    always_comb begin
        mux_idx = sel;
        if (state_nx == SCAN) begin
            mux_idx = scan_ch;
        end else if (sel_bad) begin
            mux_idx = '0;
        end
    end

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mux_idx == SEL_W'(k)) begin
                data_sel = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        dout_nx    = dout;
        cur_ch_nx  = cur_ch;
        valid_nx   = 1'b0;
        wrap_nx    = 1'b0;
        err_nx     = 1'b0;
        scan_ch_nx = '0;
        dwell_nx   = '0;

        unique case (state_nx)
            MAN: begin
                if (sel_bad) begin
                    dout_nx = '0;
                    err_nx  = 1'b1;
                end else begin
                    dout_nx   = data_sel;
                    cur_ch_nx = sel;
                    valid_nx  = 1'b1;
                end
            end
            SCAN: begin
                dout_nx   = data_sel;
                cur_ch_nx = scan_ch;
                valid_nx  = 1'b1;
                // Position (0,0) while already scanning is only
                // reachable by wrapping; on entry state is not SCAN.
                wrap_nx = (state == SCAN) &&
                          (scan_ch == '0) && (dwell == '0);
                if (dwell == DWELL_LAST) begin
                    dwell_nx   = '0;
                    scan_ch_nx = (scan_ch == CH_LAST) ? '0 : scan_ch + 1'b1;
                end else begin
                    dwell_nx   = dwell + 1'b1;
                    scan_ch_nx = scan_ch;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            scan_ch    <= '0;
            dwell      <= '0;
            dout       <= '0;
            cur_ch     <= '0;
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            scan_ch    <= scan_ch_nx;
            dwell      <= dwell_nx;
            dout       <= dout_nx;
            cur_ch     <= cur_ch_nx;
            dout_valid <= valid_nx;
            wrap       <= wrap_nx;
            sel_err    <= err_nx;
        end
    end

`ifdef MUX_NX1_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_par <= 1'b0;
        end else begin
            dout_par <= ^dout_nx;
        end
    end
`endif

endmodule
